// File: rtl/placement_cost_eval.sv
// -----------------------------------------------------------------------------
// placement_cost_eval
//
// Post-placement quality evaluator. After a start pulse it walks the edge list
// held in two external ROMs (e_a / e_b, shared address). For each edge it reads
// both endpoint coordinates from the external position RAMs (pos_X / pos_Y,
// shared address). It then accumulates three figures:
//   cost         - signed sum of per-edge Manhattan lengths (wraps at DATA_W)
//   max_len      - largest single edge length (signed compare, starts at 0)
//   unplaced_cnt - edges with any endpoint coordinate equal to -1 (saturating)
// An edge's length is |dx| + |dy| - 1. Adjacent cells therefore cost 0, and a
// self-loop (a == b) contributes -1. The -1 is left in deliberately so that
// degenerate edges show up in the totals instead of being hidden.
//
// Every memory has a one-cycle synchronous read. Each edge takes seven states:
// RD_EDGE, WAIT_EDGE, RD_A, WAIT_A, RD_B, WAIT_B, ACC.
//
// Ports
//   clk, reset        clock; synchronous active-high reset (aborts a run)
//   start             begin a run; only looked at while idle
//   edge_re/edge_addr edge ROM read strobe and edge index
//   edge_a/edge_b     edge endpoints (node ids; only ADDR_W low bits used)
//   pos_re/pos_addr   position RAM read strobe and node id
//   pos_x/pos_y       node coordinates, -1 marks an unplaced node
//   busy              high from the cycle after start through the done cycle
//   done              one-cycle pulse, results valid from then on
//   cost/max_len/unplaced_cnt/error  results, held until the next run
// All outputs are registers.
// -----------------------------------------------------------------------------
module placement_cost_eval #(
    parameter int N_EDGE = 15,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     edge_re,
    output logic [ADDR_W-1:0]        edge_addr,
    input  logic signed [DATA_W-1:0] edge_a,
    input  logic signed [DATA_W-1:0] edge_b,
    output logic                     pos_re,
    output logic [ADDR_W-1:0]        pos_addr,
    input  logic signed [DATA_W-1:0] pos_x,
    input  logic signed [DATA_W-1:0] pos_y,
    output logic                     busy,
    output logic                     done,
    output logic signed [DATA_W-1:0] cost,
    output logic signed [DATA_W-1:0] max_len,
    output logic [CNT_W-1:0]         unplaced_cnt,
    output logic                     error
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_EDGE,
        S_WAIT_EDGE,
        S_RD_A,
        S_WAIT_A,
        S_RD_B,
        S_WAIT_B,
        S_ACC,
        S_DONE
    } state_t;

    // One extra bit so that the index can reach N_EDGE == 2**ADDR_W without
    // wrapping before the last-edge test.
    localparam int IDX_W = ADDR_W + 1;
    localparam logic signed [DATA_W-1:0] ONE = DATA_W'(1);

    state_t                     state_reg, state_next;
    logic [IDX_W-1:0]           idx_reg;
    logic [ADDR_W-1:0]          node_b_reg;
    logic signed [DATA_W-1:0]   xa_reg, ya_reg, xb_reg, yb_reg;

    logic signed [DATA_W-1:0]   dx, dy, adx, ady, len;
    logic                       any_unplaced;
    logic                       last_edge;

    // Node ids wider than the RAM address are truncated on purpose.
    logic unused_bits;
    assign unused_bits = &{1'b0, edge_a[DATA_W-1:ADDR_W], edge_b[DATA_W-1:ADDR_W]};

    assign last_edge = (int'(idx_reg) + 1 >= N_EDGE);

    // Edge length is computed entirely in DATA_W signed arithmetic, so every
    // step wraps exactly as it would in the registers.
    always_comb begin
        dx           = xa_reg - xb_reg;
        dy           = ya_reg - yb_reg;
        adx          = dx[DATA_W-1] ? -dx : dx;
        ady          = dy[DATA_W-1] ? -dy : dy;
        len          = adx + ady - ONE;
        any_unplaced = (xa_reg == '1) || (ya_reg == '1) ||
                       (xb_reg == '1) || (yb_reg == '1);
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:      if (start) state_next = (N_EDGE == 0) ? S_DONE : S_RD_EDGE;
            S_RD_EDGE:   state_next = S_WAIT_EDGE;
            S_WAIT_EDGE: state_next = S_RD_A;
            S_RD_A:      state_next = S_WAIT_A;
            S_WAIT_A:    state_next = S_RD_B;
            S_RD_B:      state_next = S_WAIT_B;
            S_WAIT_B:    state_next = S_ACC;
            S_ACC:       state_next = last_edge ? S_DONE : S_RD_EDGE;
            S_DONE:      state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    // The status and strobe outputs are decoded from state_next, so that as
    // registers they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            idx_reg      <= '0;
            node_b_reg   <= '0;
            xa_reg       <= '0;
            ya_reg       <= '0;
            xb_reg       <= '0;
            yb_reg       <= '0;
            edge_re      <= 1'b0;
            edge_addr    <= '0;
            pos_re       <= 1'b0;
            pos_addr     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            cost         <= '0;
            max_len      <= '0;
            unplaced_cnt <= '0;
            error        <= 1'b0;
        end else begin
            state_reg <= state_next;
            edge_re   <= (state_next == S_RD_EDGE);
            pos_re    <= (state_next == S_RD_A) || (state_next == S_RD_B);
            busy      <= (state_next != S_IDLE);
            done      <= (state_next == S_DONE);

            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        cost         <= '0;
                        max_len      <= '0;
                        unplaced_cnt <= '0;
                        error        <= 1'b0;
                        idx_reg      <= '0;
                        edge_addr    <= '0;
                    end
                end
                S_WAIT_EDGE: begin
                    // Endpoint a is used straight away as the next read
                    // address, so only b needs to be kept.
                    pos_addr   <= edge_a[ADDR_W-1:0];
                    node_b_reg <= edge_b[ADDR_W-1:0];
                end
                S_WAIT_A: begin
                    xa_reg   <= pos_x;
                    ya_reg   <= pos_y;
                    pos_addr <= node_b_reg;
                end
                S_WAIT_B: begin
                    xb_reg <= pos_x;
                    yb_reg <= pos_y;
                end
                S_ACC: begin
                    if (any_unplaced) begin
                        if (unplaced_cnt != '1) begin
                            unplaced_cnt <= unplaced_cnt + 1'b1;
                        end
                        error <= 1'b1;
                    end else begin
                        cost <= cost + len;
                        if (len > max_len) begin
                            max_len <= len;
                        end
                    end
                    idx_reg   <= idx_reg + 1'b1;
                    edge_addr <= idx_reg[ADDR_W-1:0] + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_placement_cost_eval.sv
module tb_placement_cost_eval;
    localparam int N_EDGE = 15;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 8;
    localparam int RUN_CYC = 7 * N_EDGE + 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    always #5 clk = ~clk;

    logic edge_re, pos_re, busy, done, error;
    logic [ADDR_W-1:0] edge_addr, pos_addr;
    logic [DATA_W-1:0] edge_a, edge_b, pos_x, pos_y, cost, max_len;
    logic [CNT_W-1:0] unplaced_cnt;

    // Second build with an empty edge list
    logic start0 = 1'b0;
    logic edge_re0, pos_re0, busy0, done0, error0;
    logic [ADDR_W-1:0] edge_addr0, pos_addr0;
    logic [DATA_W-1:0] zero_data = '0;
    logic [DATA_W-1:0] cost0, max_len0;
    logic [CNT_W-1:0] unplaced_cnt0;

    logic [DATA_W-1:0] mem_ea [16];
    logic [DATA_W-1:0] mem_eb [16];
    logic [DATA_W-1:0] mem_px [16];
    logic [DATA_W-1:0] mem_py [16];

    placement_cost_eval #(.N_EDGE(N_EDGE), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start),
        .edge_re(edge_re), .edge_addr(edge_addr), .edge_a(edge_a), .edge_b(edge_b),
        .pos_re(pos_re), .pos_addr(pos_addr), .pos_x(pos_x), .pos_y(pos_y),
        .busy(busy), .done(done), .cost(cost), .max_len(max_len),
        .unplaced_cnt(unplaced_cnt), .error(error)
    );

    placement_cost_eval #(.N_EDGE(0), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut0 (
        .clk(clk), .reset(reset), .start(start0),
        .edge_re(edge_re0), .edge_addr(edge_addr0), .edge_a(zero_data), .edge_b(zero_data),
        .pos_re(pos_re0), .pos_addr(pos_addr0), .pos_x(zero_data), .pos_y(zero_data),
        .busy(busy0), .done(done0), .cost(cost0), .max_len(max_len0),
        .unplaced_cnt(unplaced_cnt0), .error(error0)
    );

    // External synchronous-read memories, one cycle latency
    always @(posedge clk) begin
        if (edge_re) begin
            edge_a <= mem_ea[edge_addr];
            edge_b <= mem_eb[edge_addr];
        end
        if (pos_re) begin
            pos_x <= mem_px[pos_addr];
            pos_y <= mem_py[pos_addr];
        end
    end

    int checks = 0;
    int errors = 0;

    // Reference results
    logic [DATA_W-1:0] exp_cost, exp_max;
    int exp_unp;
    logic exp_err;

    // Observations from the last run
    int done_cyc, n_done, n_edge_re, n_pos_re;
    logic busy_first, rst_zero_ok;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Wirelength from the edge list, using ordinary integer arithmetic
    task automatic model();
        longint c = 0;
        int m = 0;
        int u = 0;
        for (int k = 0; k < N_EDGE; k++) begin
            int a, b, xa, ya, xb, yb, len;
            a  = int'(mem_ea[k] % 16);
            b  = int'(mem_eb[k] % 16);
            xa = int'(mem_px[a]);
            ya = int'(mem_py[a]);
            xb = int'(mem_px[b]);
            yb = int'(mem_py[b]);
            if (xa == -1 || ya == -1 || xb == -1 || yb == -1) begin
                u++;
            end else begin
                len = iabs(xa - xb) + iabs(ya - yb) - 1;
                c += len;
                if (len > m) m = len;
            end
        end
        exp_cost = c[31:0];
        exp_max  = m;
        exp_unp  = (u > 255) ? 255 : u;
        exp_err  = (u != 0);
    endtask

    task automatic load_random(input bit big, input int unpl_pct);
        for (int k = 0; k < 16; k++) begin
            mem_ea[k] = $urandom();
            mem_eb[k] = $urandom();
            if (big) begin
                mem_px[k] = $urandom_range(0, 32'h1FFF_FFFF) - 32'h1000_0000;
                mem_py[k] = $urandom_range(0, 32'h1FFF_FFFF) - 32'h1000_0000;
            end else begin
                mem_px[k] = $urandom_range(0, 7);
                mem_py[k] = $urandom_range(0, 7);
            end
            if ($urandom_range(0, 99) < unpl_pct) begin
                if ($urandom_range(0, 1) == 0) mem_px[k] = '1;
                else mem_py[k] = '1;
            end
        end
    endtask

    // Pulses start, then watches a fixed window of cycles. Cycle 1 is the
    // first cycle after the edge that sampled start.
    task automatic do_run(input int rep1, input int rep2, input int rst_at, input int limit);
        done_cyc = -1; n_done = 0; n_edge_re = 0; n_pos_re = 0;
        busy_first = 1'b0; rst_zero_ok = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int cyc = 1; cyc <= limit; cyc++) begin
            @(negedge clk);
            if (cyc == 1) busy_first = busy;
            if (edge_re) n_edge_re++;
            if (pos_re) n_pos_re++;
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (rst_at > 0 && cyc == rst_at + 1) begin
                rst_zero_ok = ({edge_re, pos_re, edge_addr, pos_addr, busy, done,
                                cost, max_len, unplaced_cnt, error} == '0);
                reset = 1'b0;
            end
            start = (cyc == rep1 || cyc == rep2);
            if (rst_at > 0 && cyc == rst_at) reset = 1'b1;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({edge_re, pos_re, edge_addr, pos_addr, busy, done, cost, max_len, unplaced_cnt, error} !== '0) begin
            errors++;
            $display("FAIL reset_state: got re=%b/%b addr=%h/%h busy=%b done=%b cost=%h max=%h unp=%h err=%b, want all zero",
                     edge_re, pos_re, edge_addr, pos_addr, busy, done, cost, max_len, unplaced_cnt, error);
        end
        checks++;
        if ({busy0, done0, edge_re0, pos_re0, cost0} !== '0) begin
            errors++;
            $display("FAIL reset_state_n0: got busy=%b done=%b re=%b/%b cost=%h, want zero",
                     busy0, done0, edge_re0, pos_re0, cost0);
        end
        $display("reset: outputs idle");
    endtask

    task automatic test_chain();
        for (int k = 0; k < 16; k++) begin
            mem_px[k] = 5; mem_py[k] = 5;
            mem_ea[k] = 0; mem_eb[k] = 1;
        end
        mem_px[0] = 0; mem_py[0] = 0;
        mem_px[1] = 0; mem_py[1] = 1;
        mem_px[2] = 0; mem_py[2] = 2;
        mem_px[3] = 1; mem_py[3] = 2;
        mem_ea[1] = 1; mem_eb[1] = 2;
        mem_ea[2] = 2; mem_eb[2] = 3;
        do_run(0, 0, 0, RUN_CYC + 5);
        checks++;
        if (cost !== 0 || max_len !== 0 || unplaced_cnt !== 0 || error !== 1'b0) begin
            errors++;
            $display("FAIL chain_result: got cost=%0d max=%0d unp=%0d err=%b, want 0 0 0 0",
                     $signed(cost), $signed(max_len), unplaced_cnt, error);
        end
        checks++;
        if (done_cyc != RUN_CYC || n_done != 1) begin
            errors++;
            $display("FAIL chain_done: got cycle %0d count %0d, want cycle %0d count 1", done_cyc, n_done, RUN_CYC);
        end
        checks++;
        if (n_edge_re != N_EDGE || n_pos_re != 2 * N_EDGE || busy_first !== 1'b1) begin
            errors++;
            $display("FAIL chain_strobes: got edge_re=%0d pos_re=%0d busy1=%b, want %0d %0d 1",
                     n_edge_re, n_pos_re, busy_first, N_EDGE, 2 * N_EDGE);
        end
        $display("chain: cost=%0d max=%0d done@%0d", $signed(cost), $signed(max_len), done_cyc);
    endtask

    task automatic test_lengths();
        // Edge 0 length 5, the other 14 edges length 1
        for (int k = 0; k < 16; k++) begin
            mem_ea[k] = 0; mem_eb[k] = 2;
            mem_px[k] = 9; mem_py[k] = 9;
        end
        mem_eb[0] = 1;
        mem_px[0] = 0; mem_py[0] = 0;
        mem_px[1] = 3; mem_py[1] = 3;
        mem_px[2] = 0; mem_py[2] = 2;
        do_run(0, 0, 0, RUN_CYC + 5);
        checks++;
        if (cost !== 32'd19 || max_len !== 32'd5 || unplaced_cnt !== 0 || error !== 1'b0) begin
            errors++;
            $display("FAIL lengths: got cost=%0d max=%0d unp=%0d err=%b, want 19 5 0 0",
                     $signed(cost), $signed(max_len), unplaced_cnt, error);
        end
        $display("lengths: cost=%0d max=%0d", $signed(cost), $signed(max_len));
    endtask

    task automatic test_unplaced();
        // Edge 0 touches unplaced node 2, edge 14 is a self-loop (-1),
        // remaining 13 edges are length 2
        for (int k = 0; k < 16; k++) begin
            mem_ea[k] = 0; mem_eb[k] = 1;
        end
        mem_px[0] = 0; mem_py[0] = 0;
        mem_px[1] = 1; mem_py[1] = 2;
        mem_px[2] = '1; mem_py[2] = '1;
        mem_px[3] = 4; mem_py[3] = 4;
        mem_ea[0] = 1; mem_eb[0] = 2;
        mem_ea[14] = 3; mem_eb[14] = 3;
        do_run(0, 0, 0, RUN_CYC + 5);
        checks++;
        if (cost !== 32'd25 || max_len !== 32'd2 || unplaced_cnt !== 8'd1 || error !== 1'b1) begin
            errors++;
            $display("FAIL unplaced: got cost=%0d max=%0d unp=%0d err=%b, want 25 2 1 1",
                     $signed(cost), $signed(max_len), unplaced_cnt, error);
        end
        $display("unplaced: cost=%0d unp=%0d err=%b", $signed(cost), unplaced_cnt, error);
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            load_random(r[0], (r < 2) ? 0 : 10 * r);
            model();
            do_run(0, 0, 0, RUN_CYC + 5);
            checks++;
            if (cost !== exp_cost || max_len !== exp_max || unplaced_cnt !== exp_unp[CNT_W-1:0] || error !== exp_err) begin
                errors++;
                $display("FAIL random_%0d: got cost=%h max=%h unp=%0d err=%b, want %h %h %0d %b",
                         r, cost, max_len, unplaced_cnt, error, exp_cost, exp_max, exp_unp, exp_err);
            end
            checks++;
            if (done_cyc != RUN_CYC || n_done != 1) begin
                errors++;
                $display("FAIL random_done_%0d: got cycle %0d count %0d, want %0d 1", r, done_cyc, n_done, RUN_CYC);
            end
            $display("random %0d: cost=%h max=%h unp=%0d", r, cost, max_len, unplaced_cnt);
        end
    endtask

    task automatic test_restart_ignored();
        load_random(1'b0, 15);
        model();
        do_run(3, 10, 0, RUN_CYC + 10);
        checks++;
        if (done_cyc != RUN_CYC || n_done != 1) begin
            errors++;
            $display("FAIL restart_done: got cycle %0d count %0d, want %0d 1", done_cyc, n_done, RUN_CYC);
        end
        checks++;
        if (cost !== exp_cost || max_len !== exp_max || unplaced_cnt !== exp_unp[CNT_W-1:0]) begin
            errors++;
            $display("FAIL restart_result: got cost=%h max=%h unp=%0d, want %h %h %0d",
                     cost, max_len, unplaced_cnt, exp_cost, exp_max, exp_unp);
        end
        $display("restart: done@%0d dones=%0d", done_cyc, n_done);
    endtask

    task automatic test_reset_mid();
        load_random(1'b0, 20);
        model();
        do_run(0, 0, 20, RUN_CYC + 5);
        checks++;
        if (rst_zero_ok !== 1'b1) begin
            errors++;
            $display("FAIL midreset_zero: got outputs nonzero after reset, want all zero");
        end
        checks++;
        if (n_done != 0) begin
            errors++;
            $display("FAIL midreset_nodone: got %0d done pulses, want 0", n_done);
        end
        do_run(0, 0, 0, RUN_CYC + 5);
        checks++;
        if (cost !== exp_cost || max_len !== exp_max || unplaced_cnt !== exp_unp[CNT_W-1:0] || error !== exp_err || done_cyc != RUN_CYC) begin
            errors++;
            $display("FAIL midreset_rerun: got cost=%h max=%h unp=%0d err=%b done@%0d, want %h %h %0d %b %0d",
                     cost, max_len, unplaced_cnt, error, done_cyc, exp_cost, exp_max, exp_unp, exp_err, RUN_CYC);
        end
        $display("reset mid-run: rerun cost=%h", cost);
    endtask

    task automatic test_back_to_back();
        int dq[$];
        bit saw_busy;
        load_random(1'b1, 10);
        model();
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 1; cyc <= 2 * RUN_CYC + 10; cyc++) begin
            @(negedge clk);
            if (done) dq.push_back(cyc);
        end
        start = 1'b0;
        checks++;
        if (dq.size() != 2 || dq[0] != RUN_CYC || dq[1] != 2 * RUN_CYC + 1) begin
            errors++;
            $display("FAIL b2b_done: got %0d pulses first@%0d second@%0d, want 2 at %0d and %0d",
                     dq.size(), (dq.size() > 0) ? dq[0] : -1, (dq.size() > 1) ? dq[1] : -1,
                     RUN_CYC, 2 * RUN_CYC + 1);
        end
        // A third run was accepted while start was still high; let it drain
        saw_busy = 1'b1;
        for (int cyc = 0; cyc < RUN_CYC + 5 && saw_busy; cyc++) begin
            @(negedge clk);
            saw_busy = busy;
        end
        checks++;
        if (busy !== 1'b0 || cost !== exp_cost || max_len !== exp_max) begin
            errors++;
            $display("FAIL b2b_result: got busy=%b cost=%h max=%h, want 0 %h %h", busy, cost, max_len, exp_cost, exp_max);
        end
        $display("back-to-back: dones=%0d cost=%h", dq.size(), cost);
    endtask

    task automatic test_empty_list();
        int d_at = -1;
        int nd = 0;
        int nre = 0;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clk);
            if (done0) begin
                nd++;
                if (d_at < 0) d_at = cyc;
            end
            if (edge_re0 || pos_re0) nre++;
        end
        checks++;
        if (d_at != 1 || nd != 1) begin
            errors++;
            $display("FAIL empty_done: got cycle %0d count %0d, want 1 1", d_at, nd);
        end
        checks++;
        if (nre != 0 || cost0 !== 0 || max_len0 !== 0 || unplaced_cnt0 !== 0 || error0 !== 1'b0) begin
            errors++;
            $display("FAIL empty_result: got reads=%0d cost=%h max=%h unp=%0d err=%b, want 0 0 0 0 0",
                     nre, cost0, max_len0, unplaced_cnt0, error0);
        end
        $display("empty list: done@%0d", d_at);
    endtask

    initial begin
        test_reset();
        test_chain();
        test_lengths();
        test_unplaced();
        test_random();
        test_restart_ignored();
        test_reset_mid();
        test_back_to_back();
        test_empty_list();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
